// File: rtl/ci_mul_dispatcher_pkg.sv
// Shared types and constants for the multiplier custom-instruction dispatcher.
// The Q8 helpers are only used when CI_MUL_DISPATCHER_Q8_EN is defined.
package ci_mul_dispatcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } op_pair_t;

  localparam logic [31:0] Q8_SAT_POS = 32'h0000_7FFF;
  localparam logic [31:0] Q8_SAT_NEG = 32'hFFFF_8000;

  // Rescale a Q16.16 product to Q8.8, clamping to the signed 16-bit range.
  function automatic logic [31:0] q8_scale(input logic [31:0] prod);
    logic signed [31:0] shifted_s;
    shifted_s = $signed(prod) >>> 8;
    if (shifted_s > 32'sd32767) begin
      q8_scale = Q8_SAT_POS;
    end else if (shifted_s < -32'sd32768) begin
      q8_scale = Q8_SAT_NEG;
    end else begin
      q8_scale = {{16{shifted_s[15]}}, shifted_s[15:0]};
    end
  endfunction

endpackage

// File: rtl/ci_op_fifo.sv
// Parametric synchronous FIFO for operand pairs; full/empty are registered flags.
// A push while full is dropped even if a pop happens in the same cycle.
module ci_op_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_next_s;
  logic             full_r;
  logic             empty_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push & ~full_r;
  assign pop_ok_s  = pop & ~empty_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign full      = full_r;
  assign empty     = empty_r;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next_s = count_r;
    if (push_ok_s && !pop_ok_s) begin
      count_next_s = count_r + CW'(1'b1);
    end else if (!push_ok_s && pop_ok_s) begin
      count_next_s = count_r - CW'(1'b1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Storage, pointers and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CW'(DEPTH));
      empty_r <= (count_next_s == '0);
    end
  end

endmodule

// File: rtl/ci_mul_dispatcher.sv
// Feeds queued operand pairs to the 16x16 multiplier CI one at a time, with a done-timeout.
// Define CI_MUL_DISPATCHER_Q8_EN to return saturated signed Q8.8 results instead of raw products.
module ci_mul_dispatcher
  import ci_mul_dispatcher_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        ci_clk_en,
  output logic        ci_start,
  output logic [15:0] ci_dataa,
  output logic [15:0] ci_datab,
  input  logic [31:0] ci_result,
  input  logic        ci_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_err,
  output logic        err_sticky
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  state_e      state_r;
  state_e      state_next_s;
  op_pair_t    push_pair_s;
  op_pair_t    head_pair_s;
  logic        fifo_pop_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic [31:0] product_s;
  logic [7:0]  tmo_cnt_r;
  logic [15:0] dataa_r;
  logic [15:0] datab_r;
  logic [31:0] result_r;
  logic        err_r;
  logic        sticky_r;
  logic        start_r;
  logic        clk_en_r;
  logic        out_valid_r;

  assign push_pair_s = '{a: in_a, b: in_b};

  ci_op_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH($bits(op_pair_t))
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (in_valid),
    .pop  (fifo_pop_s),
    .wdata(push_pair_s),
    .rdata(head_pair_s),
    .full (fifo_full_s),
    .empty(fifo_empty_s)
  );

`ifdef CI_MUL_DISPATCHER_Q8_EN
  assign product_s = q8_scale(ci_result);
`else
  assign product_s = ci_result;
`endif

  assign in_ready   = ~fifo_full_s;
  assign ci_clk_en  = clk_en_r;
  assign ci_start   = start_r;
  assign ci_dataa   = dataa_r;
  assign ci_datab   = datab_r;
  assign out_valid  = out_valid_r;
  assign out_result = result_r;
  assign out_err    = err_r;
  assign err_sticky = sticky_r;

  // Next-state logic; the FIFO is popped only on the IDLE->ISSUE transition.
  always_comb begin
    state_next_s = state_r;
    fifo_pop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          state_next_s = ST_ISSUE;
          fifo_pop_s   = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (ci_done || (tmo_cnt_r == TMO_LIMIT)) begin
          state_next_s = ST_HOLD;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered CI controls and result path; controls are decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_r     <= 1'b0;
      clk_en_r    <= 1'b0;
      out_valid_r <= 1'b0;
      dataa_r     <= 16'd0;
      datab_r     <= 16'd0;
      tmo_cnt_r   <= 8'd0;
      result_r    <= 32'd0;
      err_r       <= 1'b0;
      sticky_r    <= 1'b0;
    end else begin
      start_r     <= (state_next_s == ST_ISSUE);
      clk_en_r    <= (state_next_s == ST_ISSUE) || (state_next_s == ST_WAIT);
      out_valid_r <= (state_next_s == ST_HOLD);
      if (fifo_pop_s) begin
        dataa_r <= head_pair_s.a;
        datab_r <= head_pair_s.b;
      end
      case (state_r)
        ST_ISSUE: tmo_cnt_r <= 8'd0;
        ST_WAIT: begin
          if (ci_done) begin
            result_r <= product_s;
            err_r    <= 1'b0;
          end else if (tmo_cnt_r == TMO_LIMIT) begin
            result_r <= 32'd0;
            err_r    <= 1'b1;
            sticky_r <= 1'b1;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end
        end
        default: tmo_cnt_r <= tmo_cnt_r;
      endcase
    end
  end

endmodule
